pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM that sequences the instruction-fetch/execute loop of the lab RISC-V CPU. Drives the program counter's advance/jump controls, the instruction-register load, the register-file write enable and the data-memory handshake. Sits between the PC, instruction memory, decoder/ALU and data memory. Exactly one PC update is issued per retired instruction.

## Interface
- JP_RELATIVE, 1'b0, jump_sel code for PC ← PC + rel_addr
- JP_TO_F, 1'b1, jump_sel code for PC ← f_data (JALR target)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE
- halt_req  in  1  request to stop after the current instruction
- imem_ready  in  1  instruction word valid on inst this cycle
- inst  in  32  instruction word from instruction memory
- branch_taken  in  1  ALU comparator result, valid during EXEC
- dmem_ready  in  1  data-memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load inst into instruction register
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (store)
- rf_we  out  1  register-file write enable
- pc_go_next  out  1  PC ← PC + 4
- pc_jump  out  1  PC jump enable
- pc_jump_sel  out  1  jump source select
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky: halted on unsupported opcode
- retired  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT.
- IDLE: waits for start → FETCH.
- FETCH: imem_req=1. If imem_ready=1, assert ir_we in the same cycle, latch inst[6:0] → DECODE. Otherwise stay.
- DECODE: classify the latched opcode:
  - R 0110011, I-ALU 0010011, LUI 0110111, AUIPC 0010111, load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111 → EXEC.
  - SYSTEM 1110011 → HALT; retired is incremented, no PC update.
  - Any other opcode → HALT; illegal set to 1, retired not incremented.
- EXEC: one cycle. Register branch_taken. Load/store → MEM; branch → PCUPD; all others → WB.
- MEM: dmem_req=1, dmem_we=1 for store only. Hold until dmem_ready. Then load → WB, store → PCUPD.
- WB: rf_we=1 for exactly one cycle → PCUPD.
- PCUPD: exactly one cycle, one of the following:
  - JAL or taken branch: pc_jump=1, pc_jump_sel=JP_RELATIVE.
  - JALR: pc_jump=1, pc_jump_sel=JP_TO_F.
  - Otherwise: pc_go_next=1.
  - retired += 1, wrapping modulo 2^32.
  - Next state: HALT if halt pending, else FETCH.
- halt_req may arrive in any state and is latched into a pending bit.
  - Pending bit clears only on rst.
  - halt_req in IDLE with no start goes directly to HALT.
  - halt_req and start together in IDLE: halt wins.
- HALT is absorbing; only rst exits it.
- pc_jump_sel = JP_RELATIVE whenever pc_jump=0.

## Timing
- Reset: the cycle after rst is sampled high:
  - state=IDLE, retired=0, illegal=0, halt pending cleared.
  - All strobes 0; busy=0, halted=0.
- rst mid-operation: aborts any state. No further imem_req, dmem_req, rf_we or PC pulse after the reset edge.
- Outputs are decoded from registered state, except ir_we = (state==FETCH) & imem_ready.
- Cycle counts with zero-wait memories (imem_ready/dmem_ready high on first request cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 5 cycles (F, D, E, W, P).
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Branch: 4 cycles.
- Each memory wait cycle adds 1 cycle. Requests stay asserted, and do not toggle, while waiting.
- PC strobes are single-cycle pulses. pc_go_next and pc_jump are never high together.

## Test plan
- Reset/start: hold rst 2 cycles, start pulse, inst=0x00000033 (add), zero-wait → imem_req in cycle 1, rf_we in cycle 4, pc_go_next in cycle 5, retired=1, back in FETCH.
- Branch: beq with branch_taken=1 → pc_jump=1, sel=0, no rf_we; repeat with branch_taken=0 → pc_go_next=1; 4 cycles each.
- JALR, then load with dmem_ready delayed 3 cycles → JALR: rf_we then pc_jump=1 with sel=1. Load: dmem_req high 4 cycles, dmem_we=0, total 9 cycles.
- Halt: halt_req pulse during EXEC of a store → MEM, PCUPD with pc_go_next, then HALT; halted=1, retired incremented, no further imem_req.
- Illegal: inst opcode 0x7F → HALT after DECODE, illegal=1, retired unchanged. ecall 0x00000073 → HALT, illegal=0, retired+1.
- Reset mid-MEM with dmem_ready low → next cycle IDLE, dmem_req=0, retired=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the lab RISC-V core.
// Issues exactly one PC update per retired instruction and counts retirements.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        imem_ready,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_go_next,
  output logic        pc_jump,
  output logic        pc_jump_sel,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic JP_RELATIVE = 1'b0;
  localparam logic JP_TO_F     = 1'b1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [6:0]  opcode;
  logic        taken_r;
  logic        halt_pend;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_system, is_exec_op;
  logic        unused_inst;

  assign unused_inst = ^inst[31:7];

  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign is_branch  = (opcode == OP_BRANCH);
  assign is_jal     = (opcode == OP_JAL);
  assign is_jalr    = (opcode == OP_JALR);
  assign is_system  = (opcode == OP_SYSTEM);
  assign is_exec_op = (opcode == OP_R) || (opcode == OP_I_ALU) || (opcode == OP_LUI) ||
                      (opcode == OP_AUIPC) || is_load || is_store || is_branch ||
                      is_jal || is_jalr;

  // ir_we is the only output that looks at an input; everything else is state-decoded.
  assign ir_we = (state == S_FETCH) && imem_ready;

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_go_next  = 1'b0;
    pc_jump     = 1'b0;
    pc_jump_sel = JP_RELATIVE;
    busy        = (state != S_IDLE) && (state != S_HALT);
    halted      = (state == S_HALT);
    case (state)
      S_IDLE: begin
        if (halt_req || halt_pend) state_nx = S_HALT;
        else if (start)            state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (is_exec_op) state_nx = S_EXEC;
        else            state_nx = S_HALT;
      end
      S_EXEC: begin
        if (is_load || is_store) state_nx = S_MEM;
        else if (is_branch)      state_nx = S_PCUPD;
        else                     state_nx = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) state_nx = is_load ? S_WB : S_PCUPD;
      end
      S_WB: begin
        rf_we    = 1'b1;
        state_nx = S_PCUPD;
      end
      S_PCUPD: begin
        if (is_jal || (is_branch && taken_r)) begin
          pc_jump = 1'b1;
        end else if (is_jalr) begin
          pc_jump     = 1'b1;
          pc_jump_sel = JP_TO_F;
        end else begin
          pc_go_next = 1'b1;
        end
        // A halt request arriving in this very cycle still stops after this instruction.
        state_nx = (halt_pend || halt_req) ? S_HALT : S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      opcode    <= '0;
      taken_r   <= 1'b0;
      halt_pend <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      state <= state_nx;
      if (halt_req)              halt_pend <= 1'b1;
      if (ir_we)                 opcode    <= inst[6:0];
      if (state == S_EXEC)       taken_r   <= branch_taken;
      if (state == S_DECODE && !is_exec_op && !is_system) illegal <= 1'b1;
      if (state == S_PCUPD || (state == S_DECODE && is_system))
        retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected instruction outcomes,
// a negedge monitor measures each instruction and compares on PC pulses / halt entry.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] inst = '0;
  logic        branch_taken = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, rf_we;
  logic        pc_go_next, pc_jump, pc_jump_sel, busy, halted, illegal;
  logic [31:0] retired;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .inst(inst), .branch_taken(branch_taken),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
    .pc_go_next(pc_go_next), .pc_jump(pc_jump), .pc_jump_sel(pc_jump_sel),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_halt;
    bit jump;
    bit sel;
    int cyc;
    int rf;
    int dm;
    bit we;
    int ret;
    bit ill;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t pc_rec(bit jump, bit sel, int cyc, int rf, int dm, bit we, int ret);
    exp_t e;
    e.is_halt = 1'b0; e.jump = jump; e.sel = sel; e.cyc = cyc; e.rf = rf;
    e.dm = dm; e.we = we; e.ret = ret; e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t halt_rec(int cyc, int ret, bit ill);
    exp_t e;
    e.is_halt = 1'b1; e.jump = 1'b0; e.sel = 1'b0; e.cyc = cyc; e.rf = 0;
    e.dm = 0; e.we = 1'b0; e.ret = ret; e.ill = ill;
    return e;
  endfunction

  // Monitor: per-instruction measurements, compared against the queue head.
  int mcyc = 0, mrf = 0, mdm = 0;
  bit mwe = 1'b0, hprev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (busy)     mcyc++;
    if (rf_we)    mrf++;
    if (dmem_req) mdm++;
    if (dmem_we)  mwe = 1'b1;
    if (pc_go_next || pc_jump) begin
      if (q.size() == 0) chk("unexpected_pc_pulse", 1, 0);
      else begin
        e = q.pop_front();
        chk("rec_kind_pc", 0, e.is_halt);
        chk("pc_jump", pc_jump, e.jump);
        chk("pc_go_next", pc_go_next, !e.jump);
        chk("pc_jump_sel", pc_jump_sel, e.sel);
        chk("instr_cycles", mcyc, e.cyc);
        chk("rf_we_cycles", mrf, e.rf);
        chk("dmem_req_cycles", mdm, e.dm);
        chk("dmem_we_seen", mwe, e.we);
        chk("retired_before_upd", retired, e.ret);
      end
      mcyc = 0; mrf = 0; mdm = 0; mwe = 1'b0;
    end
    if (halted && !hprev) begin
      if (q.size() == 0) chk("unexpected_halt", 1, 0);
      else begin
        e = q.pop_front();
        chk("rec_kind_halt", 1, e.is_halt);
        chk("cycles_to_halt", mcyc, e.cyc);
        chk("retired_at_halt", retired, e.ret);
        chk("illegal_at_halt", illegal, e.ill);
      end
      mcyc = 0; mrf = 0; mdm = 0; mwe = 1'b0;
    end
    if (halted)
      chk("halt_quiet", {imem_req, dmem_req, rf_we, pc_go_next, pc_jump, busy}, 0);
    if (!busy && !halted) begin
      mcyc = 0; mrf = 0; mdm = 0; mwe = 1'b0;
    end
    hprev = halted;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
    dmem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_strobes", {imem_req, dmem_req, dmem_we, rf_we, pc_go_next, pc_jump, pc_jump_sel}, 0);
  endtask

  // Drives one instruction; returns at the negedge showing its PC pulse or halt.
  task automatic exec(input logic [31:0] i, input logic tk, input int wait_n,
                      input bit do_start, input bit halt_in_exec);
    bit done = 1'b0;
    int n = 0;
    int irseen = -1;
    inst = i; imem_ready = 1'b1; branch_taken = tk;
    dmem_ready = (wait_n == 0);
    if (do_start) start = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      start = 1'b0;
      halt_req = 1'b0;
      if (ir_we && irseen < 0) irseen = c;
      if (halt_in_exec && irseen >= 0 && c == irseen + 2) halt_req = 1'b1;
      if (dmem_req) begin
        n++;
        if (n == wait_n + 1) dmem_ready = 1'b1;
      end
      if (pc_go_next || pc_jump || halted) done = 1'b1;
    end
    if (!done) chk("exec_timeout", 0, 1);
  endtask

  task automatic wait_halted();
    bit ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (halted) ok = 1'b1;
    end
    if (!ok) chk("halt_timeout", 0, 1);
  endtask

  initial begin
    do_reset();

    // add, beq taken, beq not taken, jalr, load (3 wait), jal, store with halt in EXEC
    q.push_back(pc_rec(1'b0, 1'b0, 5, 1, 0, 1'b0, 0));
    exec(32'h0000_0033, 1'b0, 0, 1'b1, 1'b0);
    q.push_back(pc_rec(1'b1, 1'b0, 4, 0, 0, 1'b0, 1));
    exec(32'h0000_0063, 1'b1, 0, 1'b0, 1'b0);
    q.push_back(pc_rec(1'b0, 1'b0, 4, 0, 0, 1'b0, 2));
    exec(32'h0000_0063, 1'b0, 0, 1'b0, 1'b0);
    q.push_back(pc_rec(1'b1, 1'b1, 5, 1, 0, 1'b0, 3));
    exec(32'h0000_8067, 1'b0, 0, 1'b0, 1'b0);
    q.push_back(pc_rec(1'b0, 1'b0, 9, 1, 4, 1'b0, 4));
    exec(32'h0000_2003, 1'b0, 3, 1'b0, 1'b0);
    q.push_back(pc_rec(1'b1, 1'b0, 5, 1, 0, 1'b0, 5));
    exec(32'h0000_006F, 1'b1, 0, 1'b0, 1'b0);
    q.push_back(pc_rec(1'b0, 1'b0, 5, 0, 1, 1'b1, 6));
    q.push_back(halt_rec(0, 7, 1'b0));
    exec(32'h0000_2023, 1'b0, 0, 1'b0, 1'b1);
    wait_halted();
    repeat (3) @(negedge clk);

    // illegal opcode 0x7F
    do_reset();
    q.push_back(halt_rec(2, 0, 1'b1));
    exec(32'h0000_007F, 1'b0, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // ecall
    do_reset();
    q.push_back(halt_rec(2, 1, 1'b0));
    exec(32'h0000_0073, 1'b0, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // start and halt_req together in IDLE: halt wins
    do_reset();
    q.push_back(halt_rec(0, 0, 1'b0));
    start = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    start = 1'b0; halt_req = 1'b0;
    chk("idle_halt_wins", halted, 1);
    repeat (2) @(negedge clk);

    // reset in the middle of a stalled load
    do_reset();
    q.push_back(pc_rec(1'b0, 1'b0, 5, 1, 0, 1'b0, 0));
    exec(32'h0000_0033, 1'b0, 0, 1'b1, 1'b0);
    begin
      bit seen = 1'b0;
      inst = 32'h0000_2003; imem_ready = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (dmem_req) seen = 1'b1;
      end
      chk("mem_stall_reached", seen, 1);
      chk("retired_before_abort", retired, 1);
      rst = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_dmem_req", dmem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_retired", retired, 0);
      repeat (2) @(negedge clk);
      chk("abort_quiet", {imem_req, dmem_req, rf_we, pc_go_next, pc_jump}, 0);
    end

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
